cursor_input_ctrl: RTL and testbench

- Upstream stage of the VGA 640x480 display path.
- Converts raw board pushbuttons/switches into the cursor position and draw/erase levels consumed by the display and grid logic: cursor_x 0..31, cursor_y 0..23, button1, button2.
- Provides input synchronisation, debouncing, single-step movement on press and hold-to-auto-repeat.
- Runs on the 25 MHz pixel clock.

---
 rtl/cursor_input_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cursor_input_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cursor_input_ctrl.sv
// Cursor input controller: turns raw pushbuttons and draw/erase switches into
// a clamped (or wrapping) grid cursor position plus debounced draw/erase levels.
// Every raw input is double-flopped and debounced; each direction button has a
// press/auto-repeat FSM that issues single-cycle step requests.
// Build option: define CURSOR_WRAP_EN to make the cursor wrap at the grid edges
// instead of saturating.
//
// Direction FSM states
//   state  | meaning
//   IDLE   | button released, waiting for a debounced press
//   DELAY  | pressed, first step issued, waiting for the repeat delay
//   REPEAT | held past the delay, issuing a step every repeat period
module cursor_input_ctrl #(
   parameter int NX            = 32,
   parameter int NY            = 24,
   parameter int X_INIT        = 0,
   parameter int Y_INIT        = 0,
   parameter int DEBOUNCE      = 250000,
   parameter int REPEAT_DELAY  = 12500000,
   parameter int REPEAT_PERIOD = 2500000,
   parameter int CNT_W         = 24
) (
   input  logic       dclk,
   input  logic       clr,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       sw_draw,
   input  logic       sw_erase,
   output logic [4:0] cursor_x,
   output logic [4:0] cursor_y,
   output logic       button1,
   output logic       button2,
   output logic       move_pulse
);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} dir_state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [4:0]       X_MAX    = 5'(NX - 1);
   localparam logic [4:0]       Y_MAX    = 5'(NY - 1);

   // bit order: 0 up, 1 down, 2 left, 3 right, 4 draw, 5 erase
   logic [5:0]       raw;
   logic [5:0]       sync1;
   logic [5:0]       sync2;
   logic [5:0]       level;
   logic [5:0]       level_nxt;
   logic [CNT_W-1:0] deb_cnt     [6];
   logic [CNT_W-1:0] deb_cnt_nxt [6];

   dir_state_t       state   [4];
   logic [CNT_W-1:0] rpt_cnt [4];
   logic [3:0]       step;

   logic [4:0] x_nxt;
   logic [4:0] y_nxt;
   logic [4:0] x_prev;
   logic [4:0] y_prev;

   assign raw     = {sw_erase, sw_draw, btn_right, btn_left, btn_down, btn_up};
   assign button1 = level[4];
   assign button2 = level[5];

   // debounce: count while synced differs from level, flip when the count completes
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         level_nxt[i]   = level[i];
         deb_cnt_nxt[i] = '0;
         if (sync2[i] != level[i]) begin
            if (deb_cnt[i] == DEB_LAST)
               level_nxt[i] = ~level[i];
            else
               deb_cnt_nxt[i] = deb_cnt[i] + CNT_W'(1);
         end
      end
   end

   // two-flop synchronisers, debounced levels and their counters
   always_ff @(posedge dclk) begin
      if (clr) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level   <= level_nxt;
         deb_cnt <= deb_cnt_nxt;
      end
   end

   // direction FSMs; they watch level_nxt so the first step is registered on
   // the same edge the debounced level rises, and a release wins over a step
   always_ff @(posedge dclk) begin
      if (clr) begin
         step <= '0;
         for (int d = 0; d < 4; d++) begin
            state[d]   <= IDLE;
            rpt_cnt[d] <= '0;
         end
      end else begin
         for (int d = 0; d < 4; d++) begin
            step[d] <= 1'b0;
            case (state[d])
               IDLE: begin
                  if (level_nxt[d]) begin
                     step[d]    <= 1'b1;
                     rpt_cnt[d] <= '0;
                     state[d]   <= DELAY;
                  end
               end
               DELAY: begin
                  if (!level_nxt[d]) begin
                     state[d] <= IDLE;
                  end else if (rpt_cnt[d] == RD_LAST) begin
                     step[d]    <= 1'b1;
                     rpt_cnt[d] <= '0;
                     state[d]   <= REPEAT;
                  end else begin
                     rpt_cnt[d] <= rpt_cnt[d] + CNT_W'(1);
                  end
               end
               REPEAT: begin
                  if (!level_nxt[d]) begin
                     state[d] <= IDLE;
                  end else if (rpt_cnt[d] == RP_LAST) begin
                     step[d]    <= 1'b1;
                     rpt_cnt[d] <= '0;
                  end else begin
                     rpt_cnt[d] <= rpt_cnt[d] + CNT_W'(1);
                  end
               end
               default: state[d] <= IDLE;
            endcase
         end
      end
   end

   // axis arbitration and edge handling; opposing steps on one axis cancel
   always_comb begin
      x_nxt = cursor_x;
      y_nxt = cursor_y;
      if (step[3] && !step[2]) begin
`ifdef CURSOR_WRAP_EN
         x_nxt = (cursor_x >= X_MAX) ? 5'd0 : cursor_x + 5'd1;
`else
         x_nxt = (cursor_x >= X_MAX) ? X_MAX : cursor_x + 5'd1;
`endif
      end else if (step[2] && !step[3]) begin
`ifdef CURSOR_WRAP_EN
         x_nxt = (cursor_x == 5'd0) ? X_MAX : cursor_x - 5'd1;
`else
         x_nxt = (cursor_x == 5'd0) ? 5'd0 : cursor_x - 5'd1;
`endif
      end
      if (step[1] && !step[0]) begin
`ifdef CURSOR_WRAP_EN
         y_nxt = (cursor_y >= Y_MAX) ? 5'd0 : cursor_y + 5'd1;
`else
         y_nxt = (cursor_y >= Y_MAX) ? Y_MAX : cursor_y + 5'd1;
`endif
      end else if (step[0] && !step[1]) begin
`ifdef CURSOR_WRAP_EN
         y_nxt = (cursor_y == 5'd0) ? Y_MAX : cursor_y - 5'd1;
`else
         y_nxt = (cursor_y == 5'd0) ? 5'd0 : cursor_y - 5'd1;
`endif
      end
   end

   // cursor registers; move_pulse fires the cycle after a coordinate changed
   always_ff @(posedge dclk) begin
      if (clr) begin
         cursor_x   <= 5'(X_INIT);
         cursor_y   <= 5'(Y_INIT);
         x_prev     <= 5'(X_INIT);
         y_prev     <= 5'(Y_INIT);
         move_pulse <= 1'b0;
      end else begin
         cursor_x   <= x_nxt;
         cursor_y   <= y_nxt;
         x_prev     <= cursor_x;
         y_prev     <= cursor_y;
         move_pulse <= (cursor_x != x_prev) || (cursor_y != y_prev);
      end
   end

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Testbench for cursor_input_ctrl with short debounce/repeat timing.
module tb_cursor_input_ctrl;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RP  = 5;
   localparam int NX  = 32;
   localparam int NY  = 24;
   localparam int FIRST = DEB + 2;

   logic       dclk = 1'b0;
   logic       clr = 1'b1;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       sw_draw = 1'b0, sw_erase = 1'b0;
   logic [4:0] cursor_x, cursor_y;
   logic       button1, button2, move_pulse;

   typedef struct {
      int x;
      int y;
   } pos_t;

   pos_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   px = 0;
   int   py = 0;

   cursor_input_ctrl #(
      .NX(NX), .NY(NY), .X_INIT(0), .Y_INIT(0),
      .DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(24)
   ) dut (
      .dclk(dclk), .clr(clr),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .sw_draw(sw_draw), .sw_erase(sw_erase),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .button1(button1), .button2(button2), .move_pulse(move_pulse)
   );

   always #5 dclk = ~dclk;

   task automatic tick();
      @(posedge dclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int move_axis(int p, int d, int n);
      int r;
      r = p + d;
`ifdef CURSOR_WRAP_EN
      if (r < 0) r = n - 1;
      else if (r > n - 1) r = 0;
`else
      if (r < 0) r = 0;
      else if (r > n - 1) r = n - 1;
`endif
      return r;
   endfunction

   // scoreboard consumer: every move_pulse must match the next expected position
   always @(negedge dclk) begin
      if (clr === 1'b0 && move_pulse === 1'b1) begin
         n_tests++;
         assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_move_pulse: observed pulse at x=%0d y=%0d expected none",
                   cursor_x, cursor_y);
         end
         if (sb_q.size() > 0) begin
            pos_t e;
            e = sb_q.pop_front();
            check("sb_x", cursor_x, e.x);
            check("sb_y", cursor_y, e.y);
         end
      end
   end

   // mask = {up, down, left, right}; pressed before edge 1, released before edge h+1
   task automatic hold(input logic [3:0] mask, input int h, input string tag);
      int s, dx, dy, nx, ny;
      {btn_up, btn_down, btn_left, btn_right} = mask;
      dx = int'(mask[0]) - int'(mask[1]);
      dy = int'(mask[2]) - int'(mask[3]);
      for (int t = 1; t <= h + 12; t++) begin
         tick();
         s = t - 1;
         if (s < h + FIRST &&
             (s == FIRST || (s >= FIRST + RD && (s - FIRST - RD) % RP == 0))) begin
            nx = move_axis(px, dx, NX);
            ny = move_axis(py, dy, NY);
            if (nx != px || ny != py) sb_q.push_back('{x: nx, y: ny});
            px = nx;
            py = ny;
         end
         check({tag, "_x"}, cursor_x, px);
         check({tag, "_y"}, cursor_y, py);
         if (t == h) {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      end
   endtask

   initial begin
      // reset with right held: fresh press once debounced after reset
      btn_right = 1'b1;
      repeat (3) tick();
      check("rst_x", cursor_x, 0);
      check("rst_y", cursor_y, 0);
      check("rst_b1", button1, 0);
      check("rst_b2", button2, 0);
      check("rst_pulse", move_pulse, 0);
      clr = 1'b0;
      hold(4'b0001, 7, "post_rst");

      // bounce shorter than the debounce window
      for (int t = 0; t < 20; t++) begin
         btn_right = ((t / 2) % 2 == 0);
         tick();
      end
      btn_right = 1'b0;
      repeat (12) tick();
      check("bounce_x", cursor_x, px);
      check("bounce_y", cursor_y, py);

      // hold with auto-repeat, then run to the right edge
      hold(4'b0001, 44, "repeat");
      hold(4'b0001, 131, "to_edge");
      hold(4'b0001, 8, "edge_right");
      hold(4'b0010, 8, "edge_left");
      hold(4'b0010, 112, "run_left");
      hold(4'b0011, 8, "opposite_x");

      // vertical edges, then a diagonal move
      hold(4'b1000, 8, "edge_up");
      hold(4'b0100, 8, "down1");
      hold(4'b0100, 8, "down2");
      hold(4'b1001, 8, "diag");
      hold(4'b1100, 8, "opposite_y");
      hold(4'b0010, 78, "left_edge");

      // draw/erase pass through together
      sw_draw  = 1'b1;
      sw_erase = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         check("draw_rise", button1, (t >= FIRST));
         check("erase_rise", button2, (t >= FIRST));
      end
      sw_draw  = 1'b0;
      sw_erase = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         check("draw_fall", button1, (t < FIRST));
         check("erase_fall", button2, (t < FIRST));
      end

      repeat (5) tick();
      check("sb_drained", sb_q.size(), 0);
      check("final_x", cursor_x, px);
      check("final_y", cursor_y, py);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
